// File: rtl/hs_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg
// Shared definitions for the handshaked byte FIFO:
//   - default WIDTH / DEPTH constants
//   - input-side FSM state type (in_state_t)
//   - output-side FSM state type (out_state_t)
// -----------------------------------------------------------------------------
package hs_pkg;

    localparam int HS_DEFAULT_WIDTH = 8;
    localparam int HS_DEFAULT_DEPTH = 8;

    // Upstream side: wait for a request, then for its release.
    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_WAIT = 1'b1
    } in_state_t;

    // Downstream side: present data, wait for the consumer's acknowledge
    // (rfd low), then wait for it to become ready again (rfd high).
    typedef enum logic [1:0] {
        OUT_IDLE    = 2'd0,
        OUT_WAIT_LO = 2'd1,
        OUT_WAIT_HI = 2'd2
    } out_state_t;

endpackage

// File: rtl/hs_sync2.sv
// -----------------------------------------------------------------------------
// hs_sync2
// Two-flop synchronizer for a single active-low handshake line. Both flops
// reset to 1 so that the synchronized line reads "inactive" out of reset.
// Ports:
//   clock - sampling clock
//   reset - asynchronous, active-high reset
//   d     - asynchronous input
//   q     - synchronized output (two clock edges of latency)
// -----------------------------------------------------------------------------
module hs_sync2
    import hs_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/hs_byte_fifo.sv
// -----------------------------------------------------------------------------
// hs_byte_fifo
// Non-fall-through FIFO between two four-phase dav_/rfd handshakes.
// An input FSM accepts one entry per upstream handshake; an output FSM
// presents one entry per downstream handshake on a registered byte_out.
//
// Optional build macro: HS_BYTE_FIFO_SYNC_EN
//   defined   - dav_in_ and rfd_out each pass through hs_sync2 (+2 edges)
//   undefined - dav_in_ and rfd_out are sampled directly
//
// Parameters:
//   DEPTH - number of entries (power of two, 2..256)
//   WIDTH - data bits per entry
// Ports:
//   clock    - single clock, rising edge
//   reset    - asynchronous, active-high reset
//   dav_in_  - upstream data valid (active low)
//   rfd_in   - ready for data to upstream
//   byte_in  - upstream data
//   dav_out_ - downstream data valid (active low)
//   rfd_out  - downstream ready for data
//   byte_out - downstream data (registered)
//   count    - number of stored entries
//   full     - count == DEPTH
//   empty    - count == 0
// -----------------------------------------------------------------------------
module hs_byte_fifo
    import hs_pkg::*;
#(
    parameter int DEPTH = HS_DEFAULT_DEPTH,
    parameter int WIDTH = HS_DEFAULT_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dav_in_,
    output logic                     rfd_in,
    input  logic [WIDTH-1:0]         byte_in,
    output logic                     dav_out_,
    input  logic                     rfd_out,
    output logic [WIDTH-1:0]         byte_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             w_dav_in_;
    logic             w_rfd_out;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    in_state_t        r_in_state;
    out_state_t       r_out_state;
    logic             r_dav_out_;
    logic [WIDTH-1:0] r_byte_out;

`ifdef HS_BYTE_FIFO_SYNC_EN
    hs_sync2 u_sync_dav_in (
        .clock (clock),
        .reset (reset),
        .d     (dav_in_),
        .q     (w_dav_in_)
    );

    hs_sync2 u_sync_rfd_out (
        .clock (clock),
        .reset (reset),
        .d     (rfd_out),
        .q     (w_rfd_out)
    );
`else
    assign w_dav_in_ = dav_in_;
    assign w_rfd_out = rfd_out;
`endif

    // Flags come straight from the registered count, so a pop that leaves
    // the FIFO not-full is visible right after that edge.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A write happens on the idle-with-request edge; a pop happens on the
    // edge the consumer acknowledges (rfd low while data is presented).
    assign w_push = (r_in_state == IN_IDLE) && !w_dav_in_ && !w_full;
    assign w_pop  = (r_out_state == OUT_WAIT_LO) && !w_rfd_out;

    // Storage: no reset, so it can map onto RAM; stale contents are
    // harmless because count is cleared.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= byte_in;
        end
    end

    // Input FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_in_state <= IN_IDLE;
            r_wr_ptr   <= '0;
        end else begin
            case (r_in_state)
                IN_IDLE: begin
                    if (w_push) begin
                        r_wr_ptr   <= r_wr_ptr + AW'(1);
                        r_in_state <= IN_WAIT;
                    end
                end
                IN_WAIT: begin
                    if (w_dav_in_) begin
                        r_in_state <= IN_IDLE;
                    end
                end
                default: r_in_state <= IN_IDLE;
            endcase
        end
    end

    // Occupancy: simultaneous push and pop cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output FSM. byte_out is loaded only in OUT_IDLE, so it holds from
    // dav_out_ falling until the next load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_state <= OUT_IDLE;
            r_rd_ptr    <= '0;
            r_dav_out_  <= 1'b1;
            r_byte_out  <= '0;
        end else begin
            case (r_out_state)
                OUT_IDLE: begin
                    if (!w_empty && w_rfd_out) begin
                        r_byte_out  <= r_mem[r_rd_ptr];
                        r_dav_out_  <= 1'b0;
                        r_out_state <= OUT_WAIT_LO;
                    end
                end
                OUT_WAIT_LO: begin
                    if (!w_rfd_out) begin
                        r_rd_ptr    <= r_rd_ptr + AW'(1);
                        r_dav_out_  <= 1'b1;
                        r_out_state <= OUT_WAIT_HI;
                    end
                end
                OUT_WAIT_HI: begin
                    if (w_rfd_out) begin
                        r_out_state <= OUT_IDLE;
                    end
                end
                default: begin
                    r_out_state <= OUT_IDLE;
                    r_dav_out_  <= 1'b1;
                end
            endcase
        end
    end

    // rfd_in is decoded from registered state only (no input-to-output path).
    assign rfd_in   = (r_in_state == IN_IDLE) && !w_full;
    assign dav_out_ = r_dav_out_;
    assign byte_out = r_byte_out;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;

endmodule

// File: doc/hs_byte_fifo.md
HS_BYTE_FIFO -- requirements
Module: hs_byte_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dav_in_  input  1  upstream data valid, active low.
REQ-006 SHALL have port rfd_in  output  1  ready-for-data to upstream, active high.
REQ-007 SHALL have port byte_in  input  WIDTH  upstream data, valid while dav_in_=0.
REQ-008 SHALL have port dav_out_  output  1  downstream data valid, active low; connects to the I/O interface's dav_in_.
REQ-009 SHALL have port rfd_out  input  1  downstream ready-for-data; connects to the I/O interface's rfd_in.
REQ-010 SHALL have port byte_out  output  WIDTH  downstream data, registered.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  current number of stored entries.
REQ-012 SHALL have ports full and empty  output  1 each  count==DEPTH and count==0.

Function
REQ-013 Input FSM SHALL have states IN_IDLE and IN_WAIT; rfd_in=1 only in IN_IDLE with full=0.
REQ-014 In IN_IDLE with dav_in_=0 and full=0, the FSM SHALL write byte_in at wr_ptr, increment wr_ptr, drive rfd_in=0 and go to IN_WAIT, all on the same edge.
REQ-015 In IN_WAIT the FSM SHALL stay until dav_in_=1, then return to IN_IDLE.
REQ-016 When full=1, dav_in_=0 SHALL be ignored and rfd_in held 0 until an entry is popped.
REQ-017 Output FSM SHALL have states OUT_IDLE, OUT_WAIT_LO and OUT_WAIT_HI.
REQ-018 In OUT_IDLE with empty=0 and rfd_out=1, the FSM SHALL load byte_out from rd_ptr, drive dav_out_=0 and go to OUT_WAIT_LO.
REQ-019 In OUT_WAIT_LO, on rfd_out=0, the FSM SHALL pop (increment rd_ptr), drive dav_out_=1 and go to OUT_WAIT_HI.
REQ-020 In OUT_WAIT_HI, on rfd_out=1, the FSM SHALL return to OUT_IDLE.
REQ-021 byte_out SHALL stay constant from dav_out_ falling until the next load.
REQ-022 The block SHALL be non-fall-through: with the FIFO empty, a write at edge k produces dav_out_=0 after edge k+1 (two-edge latency).
REQ-023 Push and pop on the same edge SHALL leave count unchanged.
REQ-024 Pop on the same edge that makes the FIFO full-then-not-full SHALL clear full before the next edge.
REQ-025 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-026 Data SHALL leave in arrival order.

Reset
REQ-027 Asserting reset SHALL immediately force: both FSMs idle, pointers 0, count 0, empty=1, full=0, rfd_in=1, dav_out_=1, byte_out=0.
REQ-028 Reset mid-handshake SHALL discard all stored and in-flight data; memory contents need not be cleared.

Configuration
REQ-029 With macro HS_BYTE_FIFO_SYNC_EN defined, dav_in_ and rfd_out SHALL each pass through a two-flop synchronizer (reset value 1) before use, adding two edges to every handshake response.
REQ-030 Without HS_BYTE_FIFO_SYNC_EN, dav_in_ and rfd_out SHALL be sampled directly, with the latencies stated above.

Structure
REQ-031 Package hs_pkg SHALL hold the input/output FSM state typedefs and encodings, plus the default WIDTH/DEPTH constants.
REQ-032 The synchronizer SHALL be sub-module hs_sync2, instantiated only under HS_BYTE_FIFO_SYNC_EN.

Verification
REQ-033 Reset then idle: count=0, empty=1, rfd_in=1, dav_out_=1, byte_out=8'h00.
REQ-034 Single byte, rfd_out=1: push 8'hF4 -> rfd_in drops the same edge; dav_out_=0 with byte_out=8'hF4 two edges after the write; pulsing rfd_out low then high -> dav_out_=1, empty=1.
REQ-035 Fill with rfd_out=0 held: push 8'h01..8'h08 -> full=1, count=8, rfd_in=0; a 9th dav_in_=0 is not written.
REQ-036 Drain after fill: 8 downstream handshakes -> byte_out sequence 8'h01..8'h08, then empty=1.
REQ-037 Simultaneous push of 8'hA5 and pop with count=3 -> count stays 3; order is preserved.
REQ-038 Reset asserted in OUT_WAIT_LO with count=2 -> dav_out_=1 and count=0 immediately; with HS_BYTE_FIFO_SYNC_EN defined, rerunning REQ-034 shows latency +2 edges.
